// File: rtl/mapper_loader.sv
`default_nettype none
// ============================================================================
// Module   : mapper_loader
// Purpose  : Parses a byte stream (CMD, START, COUNT, COUNT+1 data bytes)
//            and turns it into one-cycle writes to the gamma mapper stage.
//            CMD[1:0] picks the channel (1=R, 2=G, 3=B, 0=all). Channel 0
//            write commands are consumed and rejected with an error pulse.
//            CMD[7] requests the identity table fill.
// Config   : `MAPPER_LOADER_IDENTITY_EN enables the identity op. When the
//            macro is undefined, an identity command is rejected with an
//            error pulse and nothing is written.
// Ports    : clock      - single clock, all logic on posedge
//            reset      - asynchronous, active-high
//            in_valid   - command/data byte present
//            in_data    - command/data byte
//            in_ready   - byte accepted when in_valid & in_ready
//            mapperconf - {conf, position, data} write to the mapper stage
//            busy       - high in any state other than IDLE
//            done       - one-cycle pulse on command completion
//            error      - one-cycle pulse on a rejected command
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MAPPER_CONF_RED
  `define MAPPER_CONF_RED   8'h01
`endif
`ifndef MAPPER_CONF_GREEN
  `define MAPPER_CONF_GREEN 8'h02
`endif
`ifndef MAPPER_CONF_BLUE
  `define MAPPER_CONF_BLUE  8'h03
`endif

module mapper_loader #(
  parameter logic [7:0] IDLE_CONF = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [23:0] mapperconf,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_START = 3'd1,
    S_GET_COUNT = 3'd2,
    S_DATA      = 3'd3,
`ifdef MAPPER_LOADER_IDENTITY_EN
    S_DISCARD   = 3'd4,
    S_IDENT     = 3'd5
`else
    S_DISCARD   = 3'd4
`endif
  } state_t;

  localparam logic [23:0] c_idle_word = {IDLE_CONF, 16'h0000};

  state_t      r_state;
  logic [1:0]  r_chan;
  logic [7:0]  r_index;
  logic [7:0]  r_remaining;
  logic [23:0] r_conf;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  // Low through reset, high from the first edge after release.
  logic        r_started;
`ifdef MAPPER_LOADER_IDENTITY_EN
  // Channel-0 identity walks R, G, B in turn.
  logic        r_ident_all;
`endif

  logic        w_accept;

  function automatic logic [7:0] chan_code(input logic [1:0] ch);
    case (ch)
      2'd1:    chan_code = `MAPPER_CONF_RED;
      2'd2:    chan_code = `MAPPER_CONF_GREEN;
      2'd3:    chan_code = `MAPPER_CONF_BLUE;
      default: chan_code = IDLE_CONF;
    endcase
  endfunction

`ifdef MAPPER_LOADER_IDENTITY_EN
  assign in_ready = r_started && (r_state != S_IDENT);
`else
  assign in_ready = r_started;
`endif
  assign w_accept   = in_valid && in_ready;
  assign mapperconf = r_conf;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_chan      <= 2'd0;
      r_index     <= 8'h00;
      r_remaining <= 8'h00;
      r_conf      <= c_idle_word;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_started   <= 1'b0;
`ifdef MAPPER_LOADER_IDENTITY_EN
      r_ident_all <= 1'b0;
`endif
    end else begin
      r_started <= 1'b1;
      // Writes and pulses last exactly one cycle unless re-asserted below.
      r_conf    <= c_idle_word;
      r_done    <= 1'b0;
      r_error   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_data[7]) begin
`ifdef MAPPER_LOADER_IDENTITY_EN
              r_state     <= S_IDENT;
              r_busy      <= 1'b1;
              r_index     <= 8'h00;
              r_ident_all <= (in_data[1:0] == 2'd0);
              r_chan      <= (in_data[1:0] == 2'd0) ? 2'd1 : in_data[1:0];
`else
              r_error <= 1'b1;
`endif
            end else begin
              r_chan  <= in_data[1:0];
              r_state <= S_GET_START;
              r_busy  <= 1'b1;
            end
          end
        end

        S_GET_START: begin
          if (w_accept) begin
            r_index <= in_data;
            r_state <= S_GET_COUNT;
          end
        end

        S_GET_COUNT: begin
          if (w_accept) begin
            r_remaining <= in_data;
            r_state     <= (r_chan == 2'd0) ? S_DISCARD : S_DATA;
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_conf  <= {chan_code(r_chan), r_index, in_data};
            r_index <= r_index + 8'd1;
            if (r_remaining == 8'h00) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 8'd1;
            end
          end
        end

        S_DISCARD: begin
          if (w_accept) begin
            if (r_remaining == 8'h00) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 8'd1;
            end
          end
        end

`ifdef MAPPER_LOADER_IDENTITY_EN
        S_IDENT: begin
          r_conf  <= {chan_code(r_chan), r_index, r_index};
          r_index <= r_index + 8'd1;
          if (r_index == 8'hFF) begin
            if (r_ident_all && (r_chan != 2'd3)) begin
              r_chan <= r_chan + 2'd1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
